// File: rtl/vbuf_unpack_pkg.sv
// Shared video definitions: pixel/accumulator width derivations and the blank pixel value.
package vbuf_unpack_pkg;

   function automatic int pixelWidth(input int cDepth);
      return 3 * cDepth;
   endfunction

   function automatic int accWidth(input int dWidth, input int cDepth);
      return dWidth + pixelWidth(cDepth);
   endfunction

   // Wide enough for any pixel format in use; callers slice their own width.
   localparam int MAX_PIXEL_W = 64;
   localparam logic [MAX_PIXEL_W-1:0] BLANK_PIXEL = '0;

endpackage

// File: rtl/vbuf_unpack_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra MSB so full and empty are distinct.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             clear,
   input  logic             wrEn,
   input  logic [WIDTH-1:0] wrData,
   input  logic             rdEn,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LW-1:0]    wrPtr;
   logic [LW-1:0]    rdPtr;
   logic             wrOk;
   logic             rdOk;

   assign level  = wrPtr - rdPtr;
   assign full   = (level == LW'(DEPTH));
   assign empty  = (wrPtr == rdPtr);
   assign wrOk   = wrEn && !full && !clear;
   assign rdOk   = rdEn && !empty && !clear;
   assign rdData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wrOk) mem[wrPtr[AW-1:0]] <= wrData;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (wrOk) wrPtr <= wrPtr + LW'(1);
         if (rdOk) rdPtr <= rdPtr + LW'(1);
      end
   end

endmodule

// File: rtl/vbuf_unpack.sv
// Unpacks an LSB-first byte stream into PWIDTH-bit pixels through a FIFO and a bit accumulator.
module vbuf_unpack
   import vbuf_unpack_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int CDEPTH = 2,
   parameter int FDEPTH = 16,
   localparam int PWIDTH = pixelWidth(CDEPTH),
   localparam int LW = $clog2(FDEPTH) + 1
) (
   input  logic              PixelClk,
   input  logic              ResetN,
   input  logic [DWIDTH-1:0] ByteIn,
   input  logic              ByteValid,
   output logic              ByteReady,
   input  logic              Blank,
   input  logic              Flush,
   output logic [PWIDTH-1:0] VideoOut,
   output logic [LW-1:0]     Level,
   output logic              Underrun
);

   localparam int ACCW = accWidth(DWIDTH, CDEPTH);
   localparam int CW   = $clog2(ACCW + 1);

   if (DWIDTH < PWIDTH || FDEPTH < 4 || (FDEPTH & (FDEPTH - 1)) != 0) begin : gBadParams
      $error("vbuf_unpack: need DWIDTH >= PWIDTH and FDEPTH a power of 2, at least 4");
   end

   logic [DWIDTH-1:0] fifoHead;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              pop;
   logic              consume;
   logic [ACCW-1:0]   acc;
   logic [ACCW-1:0]   accShifted;
   logic [ACCW-1:0]   accNext;
   logic [CW-1:0]     accCnt;
   logic [CW-1:0]     remain;
   logic [CW-1:0]     accCntNext;

   sync_fifo #(.WIDTH(DWIDTH), .DEPTH(FDEPTH)) uFifo (
      .clk    (PixelClk),
      .rstN   (ResetN),
      .clear  (Flush),
      .wrEn   (ByteValid),
      .wrData (ByteIn),
      .rdEn   (pop),
      .rdData (fifoHead),
      .full   (fifoFull),
      .empty  (fifoEmpty),
      .level  (Level)
   );

   assign ByteReady = !fifoFull;

   // Refill keeps running through blanking so the first active pixel is already staged.
   always_comb begin
      consume    = !Blank && (accCnt >= CW'(PWIDTH));
      accShifted = consume ? (acc >> PWIDTH) : acc;
      remain     = consume ? (accCnt - CW'(PWIDTH)) : accCnt;
      pop        = !fifoEmpty && ((int'(remain) + DWIDTH) <= ACCW);
      accNext    = accShifted;
      accCntNext = remain;
      if (pop) begin
         accNext    = accShifted | (ACCW'(fifoHead) << remain);
         accCntNext = remain + CW'(DWIDTH);
      end
   end

   // Bits above accCnt are kept at zero so new words can be OR-ed in.
   always_ff @(posedge PixelClk or negedge ResetN) begin
      if (!ResetN) begin
         acc      <= '0;
         accCnt   <= '0;
         VideoOut <= BLANK_PIXEL[PWIDTH-1:0];
         Underrun <= 1'b0;
      end else if (Flush) begin
         acc      <= '0;
         accCnt   <= '0;
         VideoOut <= BLANK_PIXEL[PWIDTH-1:0];
         Underrun <= 1'b0;
      end else begin
         acc      <= accNext;
         accCnt   <= accCntNext;
         VideoOut <= consume ? acc[PWIDTH-1:0] : BLANK_PIXEL[PWIDTH-1:0];
         if (!Blank && !consume) Underrun <= 1'b1;
      end
   end

endmodule
